// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stalls, dcache wait freezes, control-flow
// squashes and sticky halt, plus saturating stall-cause counters.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dREN_me,
  input  logic             dWEN_me,
  input  logic             halt_me,
  input  logic             regWr_ex,
  input  logic [1:0]       regSel_ex,
  input  logic [4:0]       regDst_ex,
  input  logic [5:0]       opcode_de,
  input  logic [4:0]       rs_de,
  input  logic [4:0]       rt_de,
  input  logic             usesRt_de,
  input  logic             branchTaken_ex,
  input  logic             jump_de,
  output logic             pcEN,
  output logic             en_fd,
  output logic             en_de,
  output logic             en_em,
  output logic             en_mw,
  output logic             flush_fd,
  output logic             flush_de,
  output logic             flush_em,
  output logic             halt,
  output logic [CNT_W-1:0] ldstall_cnt,
  output logic [CNT_W-1:0] dwait_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] ld_q, dw_q, fl_q;
  logic             ld_ex, lu, dw;
  logic             sel_dw, sel_br, sel_lu, sel_jmp;

  // A JR reads rs, so the rs compare already covers it; opcode needs no decode.
  logic unused_opcode;
  assign unused_opcode = ^opcode_de;

  assign ld_ex = regWr_ex && (regSel_ex == 2'b11) && (regDst_ex != 5'd0);
  assign lu    = ld_ex && ((rs_de == regDst_ex) || (usesRt_de && (rt_de == regDst_ex)));
  assign dw    = (dREN_me || dWEN_me) && !dhit;

  always_comb begin
    pcEN     = 1'b0;
    en_fd    = 1'b0;
    en_de    = 1'b0;
    en_em    = 1'b0;
    en_mw    = 1'b0;
    flush_fd = 1'b0;
    flush_de = 1'b0;
    flush_em = 1'b0;
    halt     = 1'b0;
    sel_dw   = 1'b0;
    sel_br   = 1'b0;
    sel_lu   = 1'b0;
    sel_jmp  = 1'b0;
    if (!nRST) begin
      halt = 1'b0;
    end else if (state_q == HALT) begin
      halt = 1'b1;
    end else if (dw) begin
      sel_dw = 1'b1;
    end else begin
      {en_fd, en_de, en_em, en_mw} = 4'b1111;
      if (branchTaken_ex) begin
        sel_br   = 1'b1;
        pcEN     = 1'b1;
        flush_fd = 1'b1;
        flush_de = 1'b1;
      end else if (lu) begin
        sel_lu   = 1'b1;
        en_fd    = 1'b0;
        flush_de = 1'b1;
      end else if (jump_de) begin
        sel_jmp  = 1'b1;
        pcEN     = 1'b1;
        flush_fd = 1'b1;
      end else if (!ihit) begin
        flush_fd = 1'b1;
      end else begin
        pcEN = 1'b1;
      end
    end
  end

  // The dhit cycle of a wait is already !dw, so DWAIT needs no separate decode.
  always_comb begin
    state_d = RUN;
    if (state_q == HALT || (halt_me && !dw)) state_d = HALT;
    else if (dw)                             state_d = DWAIT;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      ld_q    <= '0;
      dw_q    <= '0;
      fl_q    <= '0;
    end else begin
      state_q <= state_d;
      if (sel_lu && ld_q != '1)              ld_q <= ld_q + 1'b1;
      if (sel_dw && dw_q != '1)              dw_q <= dw_q + 1'b1;
      if ((sel_br || sel_jmp) && fl_q != '1) fl_q <= fl_q + 1'b1;
    end
  end

  assign ldstall_cnt = ld_q;
  assign dwait_cnt   = dw_q;
  assign flush_cnt   = fl_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios plus random traffic, checked against
// a rule-table reference model; a CNT_W=4 copy exercises counter saturation.
module tb_hazard_unit;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dhit, dREN_me, dWEN_me, halt_me, regWr_ex, usesRt_de;
  logic       branchTaken_ex, jump_de;
  logic [1:0] regSel_ex;
  logic [4:0] regDst_ex, rs_de, rt_de;
  logic [5:0] opcode_de;

  logic        a_pc, a_fd, a_de, a_em, a_mw, a_ffd, a_fde, a_fem, a_h;
  logic [15:0] a_ld, a_dw, a_fl;
  logic        b_pc, b_fd, b_de, b_em, b_mw, b_ffd, b_fde, b_fem, b_h;
  logic [3:0]  b_ld, b_dw, b_fl;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_halted;
  int m_ld, m_dw, m_fl;

  always #5 CLK = ~CLK;

  hazard_unit #(.CNT_W(16)) u_dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dREN_me(dREN_me),
    .dWEN_me(dWEN_me), .halt_me(halt_me), .regWr_ex(regWr_ex), .regSel_ex(regSel_ex),
    .regDst_ex(regDst_ex), .opcode_de(opcode_de), .rs_de(rs_de), .rt_de(rt_de),
    .usesRt_de(usesRt_de), .branchTaken_ex(branchTaken_ex), .jump_de(jump_de),
    .pcEN(a_pc), .en_fd(a_fd), .en_de(a_de), .en_em(a_em), .en_mw(a_mw),
    .flush_fd(a_ffd), .flush_de(a_fde), .flush_em(a_fem), .halt(a_h),
    .ldstall_cnt(a_ld), .dwait_cnt(a_dw), .flush_cnt(a_fl));

  hazard_unit #(.CNT_W(4)) u_sat (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dREN_me(dREN_me),
    .dWEN_me(dWEN_me), .halt_me(halt_me), .regWr_ex(regWr_ex), .regSel_ex(regSel_ex),
    .regDst_ex(regDst_ex), .opcode_de(opcode_de), .rs_de(rs_de), .rt_de(rt_de),
    .usesRt_de(usesRt_de), .branchTaken_ex(branchTaken_ex), .jump_de(jump_de),
    .pcEN(b_pc), .en_fd(b_fd), .en_de(b_de), .en_em(b_em), .en_mw(b_mw),
    .flush_fd(b_ffd), .flush_de(b_fde), .flush_em(b_fem), .halt(b_h),
    .ldstall_cnt(b_ld), .dwait_cnt(b_dw), .flush_cnt(b_fl));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Which decision rule applies this cycle (1 = halted ... 7 = free run).
  function automatic int model_rule();
    bit lu, dw;
    lu = regWr_ex && regSel_ex == 2'd3 && regDst_ex != 0 &&
         (rs_de == regDst_ex || (usesRt_de && rt_de == regDst_ex));
    dw = (dREN_me || dWEN_me) && !dhit;
    if (m_halted)       return 1;
    if (dw)             return 2;
    if (branchTaken_ex) return 3;
    if (lu)             return 4;
    if (jump_de)        return 5;
    if (!ihit)          return 6;
    return 7;
  endfunction

  // {pcEN, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em, halt}
  function automatic logic [8:0] rule_outs(input int r);
    case (r)
      1:       return 9'b0_0000_000_1;
      2:       return 9'b0_0000_000_0;
      3:       return 9'b1_1111_110_0;
      4:       return 9'b0_0111_010_0;
      5:       return 9'b1_1111_100_0;
      6:       return 9'b0_1111_100_0;
      default: return 9'b1_1111_000_0;
    endcase
  endfunction

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic idle_inputs();
    ihit = 1; dhit = 1; dREN_me = 0; dWEN_me = 0; halt_me = 0; regWr_ex = 0;
    regSel_ex = 0; regDst_ex = 0; opcode_de = 0; rs_de = 0; rt_de = 0;
    usesRt_de = 0; branchTaken_ex = 0; jump_de = 0;
  endtask

  // Check one cycle against the model, then advance to the next edge.
  task automatic step();
    int r;
    bit dw;
    @(negedge CLK);
    r = model_rule();
    chk("outs16", {a_pc, a_fd, a_de, a_em, a_mw, a_ffd, a_fde, a_fem, a_h}, rule_outs(r));
    chk("outs4",  {b_pc, b_fd, b_de, b_em, b_mw, b_ffd, b_fde, b_fem, b_h}, rule_outs(r));
    chk("ld16", a_ld, sat(m_ld, 16));
    chk("dw16", a_dw, sat(m_dw, 16));
    chk("fl16", a_fl, sat(m_fl, 16));
    chk("ld4",  b_ld, sat(m_ld, 4));
    chk("dw4",  b_dw, sat(m_dw, 4));
    chk("fl4",  b_fl, sat(m_fl, 4));
    dw = (dREN_me || dWEN_me) && !dhit;
    if (r == 2) m_dw++;
    if (r == 4) m_ld++;
    if (r == 3 || r == 5) m_fl++;
    if (halt_me && !dw) m_halted = 1;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outs();
    chk("rst_outs16", {a_pc, a_fd, a_de, a_em, a_mw, a_ffd, a_fde, a_fem, a_h}, 9'd0);
    chk("rst_outs4",  {b_pc, b_fd, b_de, b_em, b_mw, b_ffd, b_fde, b_fem, b_h}, 9'd0);
    chk("rst_cnt16", {a_ld, a_dw, a_fl}, 48'd0);
    chk("rst_cnt4",  {b_ld, b_dw, b_fl}, 12'd0);
  endtask

  task automatic load_use(input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt,
                          input bit urt);
    idle_inputs();
    regWr_ex = 1; regSel_ex = 2'd3; regDst_ex = dst; rs_de = rs; rt_de = rt; usesRt_de = urt;
  endtask

  initial begin
    int b_ld0, b_dw0, b_fl0;
    idle_inputs();
    nRST = 0;
    m_halted = 0; m_ld = 0; m_dw = 0; m_fl = 0;
    #2;
    // Reset forces outputs low even with active-looking inputs
    ihit = 1; branchTaken_ex = 1;
    #1;
    check_reset_outs();
    idle_inputs();
    @(posedge CLK); #1;
    nRST = 1;

    // lw $2 in EX, add $3,$2,$4 in decode: one bubble, then free run
    b_ld0 = m_ld;
    load_use(5'd2, 5'd2, 5'd4, 1);
    step();
    idle_inputs();
    step();
    chk("lu_one_cycle", a_ld, 16'(b_ld0 + 1));

    // $zero destination never stalls
    load_use(5'd0, 5'd0, 5'd7, 1);
    step();

    // rt match ignored when decode does not read rt
    load_use(5'd5, 5'd1, 5'd5, 0);
    step();

    // JR $2 behind lw $2: stall, then the jump proceeds once the lw is in mem
    load_use(5'd2, 5'd2, 5'd0, 0);
    jump_de = 1;
    step();
    idle_inputs();
    jump_de = 1; rs_de = 5'd2; dREN_me = 1;
    step();

    // 3-cycle dcache miss freezes everything, dhit cycle advances
    b_dw0 = int'(a_dw);
    idle_inputs();
    dREN_me = 1; dhit = 0;
    repeat (3) step();
    dhit = 1;
    step();
    chk("dwait_3", 32'(int'(a_dw) - b_dw0), 32'd3);

    // taken branch beats load-use and imem miss
    b_ld0 = int'(a_ld); b_fl0 = int'(a_fl);
    load_use(5'd3, 5'd3, 5'd0, 0);
    branchTaken_ex = 1; ihit = 0;
    step();
    chk("br_ld_same", a_ld, 16'(b_ld0));
    chk("br_fl_inc", a_fl, 16'(b_fl0 + 1));

    // imem miss alone
    idle_inputs();
    ihit = 0;
    step();

    // random traffic, halt excluded
    for (int i = 0; i < 400; i++) begin
      ihit           = ($urandom_range(0, 3) != 0);
      dhit           = ($urandom_range(0, 2) != 0);
      dREN_me        = ($urandom_range(0, 3) == 0);
      dWEN_me        = ($urandom_range(0, 5) == 0);
      halt_me        = 0;
      regWr_ex       = $urandom_range(0, 1);
      regSel_ex      = 2'($urandom_range(0, 3));
      regDst_ex      = 5'($urandom_range(0, 3));
      rs_de          = 5'($urandom_range(0, 3));
      rt_de          = 5'($urandom_range(0, 3));
      usesRt_de      = $urandom_range(0, 1);
      opcode_de      = 6'($urandom);
      branchTaken_ex = ($urandom_range(0, 7) == 0);
      jump_de        = ($urandom_range(0, 5) == 0);
      step();
    end

    // 20 consecutive load-use events push the narrow counter to its ceiling
    load_use(5'd9, 5'd9, 5'd0, 0);
    repeat (20) step();
    chk("ld_sat4", b_ld, 4'hF);

    // halt with pending store: frozen 2 cycles, halt on the dhit cycle's edge
    idle_inputs();
    halt_me = 1; dWEN_me = 1; dhit = 0;
    repeat (2) step();
    dhit = 1;
    step();
    chk("halt_set", a_h, 1'b1);
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      branchTaken_ex = $urandom_range(0, 1);
      jump_de        = $urandom_range(0, 1);
      dREN_me        = $urandom_range(0, 1);
      dhit           = $urandom_range(0, 1);
      step();
    end

    // async reset out of HALT
    #2;
    nRST = 0;
    #1;
    check_reset_outs();
    m_halted = 0; m_ld = 0; m_dw = 0; m_fl = 0;
    @(posedge CLK); #1;
    nRST = 1;
    idle_inputs();
    step();
    load_use(5'd4, 5'd4, 5'd0, 0);
    step();
    idle_inputs();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline control block for the five-stage MIPS core. It sits beside the forwarding unit and covers the cases forwarding cannot resolve: load-use dependencies, data-memory wait states, control-flow squashes and halt. It drives the PC enable plus per-latch enable and flush signals for the fetch/decode, decode/execute, execute/mem and mem/writeback registers. It also keeps saturating stall-cause counters for performance debug.

## Interface
- CNT_W, 16, width of each performance counter
- CLK  in  1  core clock, rising edge
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction fetch completes this cycle
- dhit  in  1  data access in mem stage completes this cycle
- dREN_me, dWEN_me  in  1 each  mem-stage load / store request
- halt_me  in  1  HALT opcode has reached mem stage
- regWr_ex  in  1  EX instruction writes a register
- regSel_ex  in  2  EX writeback source; 2'b11 = dmemload
- regDst_ex  in  5  EX destination register
- opcode_de  in  6  decode-stage opcode
- rs_de, rt_de  in  5 each  decode-stage source registers
- usesRt_de  in  1  decode instruction reads rt (R-type, beq/bne, sw)
- branchTaken_ex  in  1  branch resolved taken in EX
- jump_de  in  1  J/JAL/JR in decode (target redirected this cycle)
- pcEN  out  1  PC register update
- en_fd, en_de, en_em, en_mw  out  1 each  latch enables
- flush_fd, flush_de, flush_em  out  1 each  load bubble (zeros) on next edge
- halt  out  1  core halted (sticky)
- ldstall_cnt, dwait_cnt, flush_cnt  out  CNT_W each  stall-cause counters

## Operation
- State register with states RUN, DWAIT and HALT. All outputs are combinational from state and inputs. Counters are registered.
- **Load-use hazard (lu):** all of the following hold:
  - regWr_ex=1, regSel_ex=2'b11 and regDst_ex≠0;
  - and either rs_de==regDst_ex, or (usesRt_de and rt_de==regDst_ex).
  - A JR in decode whose rs matches under the same condition is also lu, because the forwarding unit cannot supply dmemload from EX.
- **Data wait (dw):** (dREN_me|dWEN_me) and !dhit.
- **Decision priority, highest first.** In every case, enables and flushes not listed are 0, except unlisted en_* = 1 in the lu, branch, jump and imem-wait cases.
  1. HALT state: everything 0 and halt=1.
  2. dw: pcEN=0 and all en_*=0. The pipeline freezes.
  3. branchTaken_ex: pcEN=1, flush_fd=1, flush_de=1. lu is ignored because the decode instruction is squashed.
  4. lu: pcEN=0, en_fd=0, flush_de=1. Exactly one bubble enters EX per load.
  5. jump_de: pcEN=1, flush_fd=1.
  6. !ihit: pcEN=0, flush_fd=1. Downstream stages advance.
  7. Otherwise all en_*=1, pcEN=1 and no flush.
- Any flush_X=1 implies the corresponding en_X=1. A flush always overrides a hold.
- **Transitions:**
  - RUN→DWAIT on dw.
  - DWAIT→RUN on the cycle dhit=1. That cycle evaluates as RUN, so the latches advance.
  - Any state→HALT when halt_me=1 and not dw.
  - HALT exits only on reset.
- **Counters** saturate at all-ones and never wrap:
  - ldstall_cnt +1 each cycle rule 4 is selected;
  - dwait_cnt +1 each cycle rule 2 is selected;
  - flush_cnt +1 each cycle rule 3 or 5 is selected.
- halt_me coincident with dw: the store/load finishes first, and HALT is entered on the dhit cycle.

## Timing
- Reset (nRST=0, asynchronous):
  - state=RUN and all counters=0;
  - outputs are forced pcEN=0, en_*=0, flush_*=0, halt=0 while nRST is low.
- First rising edge after deassertion evaluates normally.
- Decision latency is zero cycles. Enables and flushes take effect on the same rising edge that samples the inputs.
- A load-use stall costs exactly 1 cycle. A taken branch costs 2 squashed slots. A jump costs 1.
- A dcache miss of N wait cycles freezes the pipeline for N cycles. dwait_cnt increases by N.
- Reset asserted mid-DWAIT or in HALT returns to RUN immediately. Pending requests are dropped by the latches' own reset.
- Counter saturation: at all-ones, further events leave the value unchanged.

## Test plan
- lw $2 in EX, add $3,$2,$4 in decode, ihit=dhit=1 → one cycle with pcEN=0, en_fd=0, flush_de=1; next cycle all en=1; ldstall_cnt=1.
- Same lw with rs_de=0 and regDst_ex=0 → no stall.
- lw in EX with JR $2 in decode (rs_de=2) → stall 1 cycle; then no stall once the lw is in mem.
- dREN_me=1, dhit low for 3 cycles then high → pcEN and all en 0 for 3 cycles, state DWAIT; on the dhit cycle en=1, state RUN; dwait_cnt=3.
- branchTaken_ex=1 while lu is also true and ihit=0 → pcEN=1, flush_fd=1, flush_de=1, ldstall_cnt unchanged, flush_cnt+1.
- halt_me=1 with dWEN_me=1, dhit low 2 cycles → frozen 2 cycles, then halt=1 sticky with outputs 0. Assert nRST low → halt=0 and counters 0 immediately.
- Preload counters near saturation (CNT_W=4) with 20 load-use events → ldstall_cnt=15.
